spi_adc_responder: RTL and testbench
====================================

# spi_adc_responder

SPI responder (slave) for the same 3-wire-plus-select SPI link the ADC/DAC initiator drives. It oversamples `spi_sck`, `spi_cs` and `spi_mosi` in the `CLK50MHZ` domain and shifts in one WIDTH-bit frame per chip-select window. At the same time it shifts out a WIDTH-bit reply word on `spi_miso`. It serves as the on-chip ADC/peripheral model for system benches and as a control-port endpoint when the FPGA is slaved to an external controller.

## Interface
- `WIDTH`, 32: frame length in bits, MSB first; legal range 2..64.
- `CLK50MHZ` in 1: system clock; every register in the block is clocked on its rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `spi_sck` in 1: SPI clock from the initiator; asynchronous to `CLK50MHZ`; idles low.
- `spi_cs` in 1: chip select, active low; asynchronous.
- `spi_mosi` in 1: serial data from the initiator; asynchronous.
- `spi_miso` out 1: serial reply data; registered.
- `tx_data` in WIDTH: reply word; sampled on the detected falling edge of `spi_cs`.
- `rx_data` out WIDTH: last accepted frame; held until the next accepted frame.
- `rx_valid` out 1: one-cycle pulse; `rx_data` is updated in the same cycle.
- `frame_err` out 1: one-cycle pulse on a malformed frame.
- `busy` out 1: high while in ACTIVE.

## Operation
- Synchronizers: two flops each on `spi_sck`, `spi_cs` and `spi_mosi`, then one history register per line for edge detection.
  - Reset values: sck=0, cs=0, mosi=0.
  - The cs synchronizer resets to "asserted" on purpose.
- State machine: RESYNC, IDLE, ACTIVE. Reset enters RESYNC.
  - RESYNC → IDLE when synced cs=1.
  - IDLE → ACTIVE on cs falling edge. In that cycle:
    - shiftreg_tx <= `tx_data`
    - `spi_miso` <= `tx_data[WIDTH-1]`
    - bit counter <= 0
  - ACTIVE, sck rising edge:
    - shiftreg_rx <= {shiftreg_rx[WIDTH-2:0], mosi_sync}
    - bit counter increments and saturates at WIDTH+1.
  - ACTIVE, sck falling edge:
    - If counter < WIDTH: `spi_miso` <= next tx bit (shift left).
    - Otherwise: `spi_miso` <= 0.
  - ACTIVE → IDLE on cs rising edge. If counter == WIDTH: rx_data <= shiftreg_rx and pulse `rx_valid`.
- Edges on sck while in IDLE or RESYNC are ignored.
- If a cs rising edge and an sck edge are detected in the same cycle, the cs edge wins and the sck edge is discarded.
- Bit counter width is clog2(WIDTH+2). Saturation at WIDTH+1 prevents wrap-around on over-long frames.
- Reset mid-frame: all state clears immediately. The block sits in RESYNC (synced cs resets to 0) until cs is seen high, so a partial frame is never accepted.
- Reset values: `spi_miso`=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `busy`=0.

## Timing
- Detection latency:
  - A pin edge is detected on the 3rd `CLK50MHZ` rising edge after the pin changes (2 sync flops + history).
  - `spi_miso` changes 1 cycle after detection, i.e. 4 cycles after the `spi_sck` falling pin edge.
- Input requirements:
  - `spi_sck` high and low phases ≥ 4 `CLK50MHZ` cycles each.
  - `spi_cs` fall to first sck rise ≥ 4 cycles.
  - Last sck fall to cs rise ≥ 4 cycles.
  - cs high time between frames ≥ 4 cycles.
- Initiator sampling: the initiator samples `spi_miso` on sck falling edge and `spi_mosi` is stable around sck rising edge (mode 0).
- `rx_valid` and `frame_err` are asserted in the cycle after the cs rising edge is detected. They are never asserted together.
- `busy` rises the cycle after the cs falling edge is detected and falls together with the `rx_valid`/`frame_err` cycle.

## Configuration
- Macro: `SPI_ADC_RESPONDER_FRAME_CHECK_EN`.
- Defined:
  - A frame with counter ≠ WIDTH at cs rise pulses `frame_err`.
  - `rx_valid` stays low and `rx_data` is unchanged.
- Undefined:
  - `frame_err` is tied 0.
  - Any frame with counter ≥ 1 pulses `rx_valid`.
  - `rx_data` takes the shift register, i.e. the last min(count, WIDTH) bits, right-aligned and zero-filled above.
  - A frame with counter = 0 produces no pulse.

## Test plan
- WIDTH=32, `tx_data`=0x12345678, initiator sends 0xA5A50F0F with 5-cycle sck phases:
  - `rx_data`=0xA5A50F0F with a single `rx_valid` pulse.
  - Initiator captures 0x12345678.
  - `busy` is high for the whole window.
- Frame check defined, 31-bit frame: `frame_err` pulses once, `rx_valid`=0, `rx_data` holds its previous value.
- 33-bit frame: 33rd miso bit = 0; `frame_err` pulses; the counter stays at 33 and does not wrap.
- `RST` low for 2 cycles after bit 10 with cs still low:
  - All outputs are 0 and no pulse occurs while cs stays low.
  - After cs goes high, a new full frame 0x0000FFFF is accepted correctly.
- Back-to-back frames with cs high 4 cycles, `tx_data` changed from 0xDEADBEEF to 0x00000001 between them: both replies and both received words are correct, two `rx_valid` pulses.
- Frame check undefined, 8-bit frame 0xC3: `rx_valid` pulses, `rx_data`=0x000000C3, `frame_err`=0.

Source files
------------

// File: rtl/spi_adc_responder_if.sv
// spi_adc_responder_if: SPI pins plus parallel reply/receive bus.
// slave = responder side, master = initiator/system side.
interface spi_adc_responder_if #(
   parameter int WIDTH = 32
);
   logic             spi_sck;
   logic             spi_cs;
   logic             spi_mosi;
   logic             spi_miso;
   logic [WIDTH-1:0] tx_data;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             frame_err;
   logic             busy;

   modport master (
      output spi_sck, spi_cs, spi_mosi, tx_data,
      input  spi_miso, rx_data, rx_valid, frame_err, busy
   );

   modport slave (
      input  spi_sck, spi_cs, spi_mosi, tx_data,
      output spi_miso, rx_data, rx_valid, frame_err, busy
   );
endinterface

// File: rtl/spi_adc_responder.sv
// spi_adc_responder: oversampled SPI mode-0 responder, one WIDTH-bit
// frame per cs window, MSB first, reply word shifted out on miso.
// Ports: CLK50MHZ, RST (async active-low), bus (slave modport:
//   spi_sck/cs/mosi in, spi_miso out, tx_data in, rx_data/rx_valid/
//   frame_err/busy out).
// Option: define SPI_ADC_RESPONDER_FRAME_CHECK_EN to reject frames
//   whose bit count is not exactly WIDTH (pulses frame_err instead).
module spi_adc_responder #(
   parameter int WIDTH = 32
) (
   input  logic CLK50MHZ,
   input  logic RST,
   spi_adc_responder_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] CNT_W   = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH + 1);

   localparam logic [1:0] S_RESYNC = 2'd0;
   localparam logic [1:0] S_IDLE   = 2'd1;
   localparam logic [1:0] S_ACTIVE = 2'd2;

   logic sck_s1_q, sck_s2_q, sck_h_q;
   logic cs_s1_q, cs_s2_q, cs_h_q;
   logic mosi_s1_q, mosi_s2_q, mosi_h_q;
   logic sck_rise_q, sck_fall_q, cs_rise_q, cs_fall_q;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] txsr_q, txsr_d;
   logic [WIDTH-1:0] rxsr_q, rxsr_d;
   logic [WIDTH-1:0] rxd_q, rxd_d;
   logic             miso_q, miso_d;
   logic             vld_q, vld_d;
   logic             err_q, err_d;

   // Edge flags are registered, so they line up with mosi_h_q:
   // both reflect the same synchronized sample.
   always_ff @(posedge CLK50MHZ or negedge RST) begin
      if (!RST) begin
         sck_s1_q   <= 1'b0;
         sck_s2_q   <= 1'b0;
         sck_h_q    <= 1'b0;
         cs_s1_q    <= 1'b0;
         cs_s2_q    <= 1'b0;
         cs_h_q     <= 1'b0;
         mosi_s1_q  <= 1'b0;
         mosi_s2_q  <= 1'b0;
         mosi_h_q   <= 1'b0;
         sck_rise_q <= 1'b0;
         sck_fall_q <= 1'b0;
         cs_rise_q  <= 1'b0;
         cs_fall_q  <= 1'b0;
      end else begin
         sck_s1_q   <= bus.spi_sck;
         sck_s2_q   <= sck_s1_q;
         sck_h_q    <= sck_s2_q;
         cs_s1_q    <= bus.spi_cs;
         cs_s2_q    <= cs_s1_q;
         cs_h_q     <= cs_s2_q;
         mosi_s1_q  <= bus.spi_mosi;
         mosi_s2_q  <= mosi_s1_q;
         mosi_h_q   <= mosi_s2_q;
         sck_rise_q <= sck_s2_q & ~sck_h_q;
         sck_fall_q <= ~sck_s2_q & sck_h_q;
         cs_rise_q  <= cs_s2_q & ~cs_h_q;
         cs_fall_q  <= ~cs_s2_q & cs_h_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      txsr_d  = txsr_q;
      rxsr_d  = rxsr_q;
      rxd_d   = rxd_q;
      miso_d  = miso_q;
      vld_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         // cs syncs reset to "asserted": wait until cs is truly high
         // so a frame cut by reset is never picked up half way.
         S_RESYNC: begin
            if (cs_h_q) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (cs_fall_q) begin
               state_d = S_ACTIVE;
               txsr_d  = bus.tx_data;
               miso_d  = bus.tx_data[WIDTH-1];
               cnt_d   = '0;
               rxsr_d  = '0;
            end
         end
         S_ACTIVE: begin
            if (cs_rise_q) begin
               state_d = S_IDLE;
`ifdef SPI_ADC_RESPONDER_FRAME_CHECK_EN
               if (cnt_q == CNT_W) begin
                  rxd_d = rxsr_q;
                  vld_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
`else
               if (cnt_q != '0) begin
                  rxd_d = rxsr_q;
                  vld_d = 1'b1;
               end
`endif
            end else if (sck_rise_q) begin
               rxsr_d = {rxsr_q[WIDTH-2:0], mosi_h_q};
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            end else if (sck_fall_q) begin
               if (cnt_q < CNT_W) begin
                  miso_d = txsr_q[WIDTH-2];
                  txsr_d = {txsr_q[WIDTH-2:0], 1'b0};
               end else begin
                  miso_d = 1'b0;
               end
            end
         end
         default: state_d = S_RESYNC;
      endcase
   end

   always_ff @(posedge CLK50MHZ or negedge RST) begin
      if (!RST) begin
         state_q <= S_RESYNC;
         cnt_q   <= '0;
         txsr_q  <= '0;
         rxsr_q  <= '0;
         rxd_q   <= '0;
         miso_q  <= 1'b0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         txsr_q  <= txsr_d;
         rxsr_q  <= rxsr_d;
         rxd_q   <= rxd_d;
         miso_q  <= miso_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
      end
   end

   assign bus.spi_miso  = miso_q;
   assign bus.rx_data   = rxd_q;
   assign bus.rx_valid  = vld_q;
   assign bus.frame_err = err_q;
   assign bus.busy      = (state_q == S_ACTIVE);
endmodule

// File: tb/tb_spi_adc_responder.sv
// tb_spi_adc_responder: SPI initiator model plus frame-level reference
// for spi_adc_responder; directed frames then random frames.
module tb_spi_adc_responder;
   localparam int W = 32;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   vcnt = 0;
   int   ecnt = 0;
   int   vbase, ebase;
   bit   pend = 0;
   int   exp_v, exp_e;
   logic [63:0] exp_rx = '0;

   spi_adc_responder_if #(.WIDTH(W)) bus ();

   spi_adc_responder #(.WIDTH(W)) dut (
      .CLK50MHZ (clk),
      .RST      (rst_n),
      .bus      (bus.slave)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always begin
      @(posedge clk);
      #1;
      if (bus.rx_valid === 1'b1) vcnt++;
      if (bus.frame_err === 1'b1) ecnt++;
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] lowmask(input int n);
      return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
   endfunction

   task automatic check_pending();
      chk("rx_valid_pulses", 64'(vcnt - vbase), 64'(exp_v));
      chk("frame_err_pulses", 64'(ecnt - ebase), 64'(exp_e));
      chk("rx_data", 64'(bus.rx_data), exp_rx);
      pend = 0;
   endtask

   task automatic do_bits(input int n, input logic [63:0] word,
                          input int ph, output logic [63:0] cap,
                          output int busy_lo);
      cap = '0;
      busy_lo = 0;
      for (int i = 0; i < n; i++) begin
         bus.spi_mosi = word[n-1-i];
         repeat (ph) @(negedge clk);
         bus.spi_sck = 1'b1;
         repeat (ph) @(negedge clk);
         cap = {cap[62:0], bus.spi_miso};
         if (bus.busy !== 1'b1) busy_lo++;
         bus.spi_sck = 1'b0;
      end
      repeat (ph) @(negedge clk);
   endtask

   task automatic frame(input int n, input logic [63:0] word,
                        input logic [W-1:0] tx, input int ph,
                        input int hold);
      logic [63:0] cap, t, ecap;
      int blo, m;
      word = word & lowmask(n);
      bus.tx_data = tx;
      bus.spi_cs = 1'b0;
      repeat (5) @(negedge clk);
      if (pend) check_pending();
      do_bits(n, word, ph, cap, blo);
      t = 64'(tx);
      ecap = (n <= W) ? (t >> (W - n)) : (t << (n - W));
      if (n > 0) begin
         chk("miso_reply", cap, ecap);
         chk("busy_window", 64'(blo), 64'd0);
      end
`ifdef SPI_ADC_RESPONDER_FRAME_CHECK_EN
      exp_v = (n == W) ? 1 : 0;
      exp_e = (n == W) ? 0 : 1;
      if (n == W) exp_rx = word;
`else
      exp_e = 0;
      exp_v = (n >= 1) ? 1 : 0;
      m = (n < W) ? n : W;
      if (n >= 1) exp_rx = word & lowmask(m);
`endif
      vbase = vcnt;
      ebase = ecnt;
      bus.spi_cs = 1'b1;
      pend = 1;
      repeat (hold) @(negedge clk);
   endtask

   task automatic flush();
      repeat (10) @(negedge clk);
      if (pend) check_pending();
   endtask

   initial begin
      logic [63:0] cap;
      int blo, n, sel;
      rst_n = 1'b0;
      bus.spi_sck = 1'b0;
      bus.spi_cs = 1'b1;
      bus.spi_mosi = 1'b0;
      bus.tx_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_miso", 64'(bus.spi_miso), 64'd0);
      chk("rst_rx_data", 64'(bus.rx_data), 64'd0);
      chk("rst_rx_valid", 64'(bus.rx_valid), 64'd0);
      chk("rst_frame_err", 64'(bus.frame_err), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);

      frame(W, 64'hA5A50F0F, 32'h12345678, 5, 8);
      frame(W - 1, 64'h7ABC_1234, 32'hCAFEF00D, 5, 8);
      frame(W + 1, 64'h1_8765_4321, 32'h89ABCDEF, 5, 8);
      flush();

      bus.tx_data = 32'h0F0F1234;
      bus.spi_cs = 1'b0;
      repeat (5) @(negedge clk);
      do_bits(10, 64'h2AB, 5, cap, blo);
      vbase = vcnt;
      ebase = ecnt;
      rst_n = 1'b0;
      #1;
      chk("midrst_miso", 64'(bus.spi_miso), 64'd0);
      chk("midrst_rx_data", 64'(bus.rx_data), 64'd0);
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_rx_valid", 64'(bus.rx_valid), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_bits(6, 64'h3F, 5, cap, blo);
      chk("midrst_busy_low", 64'(blo), 64'd6);
      bus.spi_cs = 1'b1;
      repeat (10) @(negedge clk);
      chk("midrst_no_valid", 64'(vcnt - vbase), 64'd0);
      chk("midrst_no_err", 64'(ecnt - ebase), 64'd0);
      chk("midrst_rx_zero", 64'(bus.rx_data), 64'd0);
      exp_rx = '0;
      frame(W, 64'h0000FFFF, 32'h55AA55AA, 5, 8);
      flush();

      frame(W, {$urandom, $urandom}, 32'hDEADBEEF, 5, 4);
      frame(W, {$urandom, $urandom}, 32'h00000001, 5, 8);
      frame(8, 64'hC3, 32'h0BADCAFE, 5, 8);
      frame(0, 64'h0, 32'h11111111, 5, 8);

      for (int k = 0; k < 20; k++) begin
         sel = $urandom_range(0, 5);
         case (sel)
            0: n = W;
            1: n = W - 1;
            2: n = W + 1;
            3: n = $urandom_range(1, 8);
            4: n = 0;
            default: n = W;
         endcase
         frame(n, {$urandom, $urandom}, $urandom,
               $urandom_range(4, 7), $urandom_range(4, 9));
      end
      flush();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
